// File: rtl/nn_stage1_pkg.sv
// ---------------------------------------------------------------------------
// nn_stage1_pkg
// Shared constants and state encoding for the first-stage patch extraction
// control path (patch_sequencer and the downstream column_index_counter).
// No ports; import with "import nn_stage1_pkg::*;".
// ---------------------------------------------------------------------------
package nn_stage1_pkg;

  localparam int IMG_W           = 12;   // image width and height, pixels
  localparam int QUAD_W          = 6;    // quadrant width and height
  localparam int KERNEL          = 3;    // patch edge and stride
  localparam int PIXELS_PER_PASS = IMG_W * IMG_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/patch_sequencer_position_counter.sv
// ---------------------------------------------------------------------------
// patch_position_counter
// Nested position counters for the patch walk, innermost first:
//   kcol 0..2, krow 0..2, pcol 0..1, prow 0..1, quad 0..3.
// Each counter wraps to 0 on saturation and carries into the next one.
// Ports:
//   clock, clear    : clock and synchronous active-high clear (zeroes all)
//   advance         : step to the next pixel position
//   kcol..quad      : current position
//   kcol_wrap       : kcol is at its last value (end of a kernel row)
//   krow_wrap       : last pixel of a patch
//   prow_wrap       : last pixel of a quadrant
//   quad_wrap       : last pixel of the whole image
// ---------------------------------------------------------------------------
module patch_position_counter
  import nn_stage1_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       advance,
  output logic [1:0] kcol,
  output logic [1:0] krow,
  output logic       pcol,
  output logic       prow,
  output logic [1:0] quad,
  output logic       kcol_wrap,
  output logic       krow_wrap,
  output logic       prow_wrap,
  output logic       quad_wrap
);

  logic pcol_wrap;

  // Wrap flags are cumulative: each one means "this counter and all inner
  // counters are saturated", i.e. the carry out of that level.
  assign kcol_wrap = (kcol == 2'(KERNEL - 1));
  assign krow_wrap = kcol_wrap && (krow == 2'(KERNEL - 1));
  assign pcol_wrap = krow_wrap && pcol;
  assign prow_wrap = pcol_wrap && prow;
  assign quad_wrap = prow_wrap && (quad == 2'd3);

  always_ff @(posedge clock) begin
    if (clear) begin
      kcol <= 2'd0;
      krow <= 2'd0;
      pcol <= 1'b0;
      prow <= 1'b0;
      quad <= 2'd0;
    end else if (advance) begin
      kcol <= kcol_wrap ? 2'd0 : kcol + 2'd1;
      if (kcol_wrap) krow <= krow_wrap ? 2'd0 : krow + 2'd1;
      if (krow_wrap) pcol <= ~pcol;
      if (pcol_wrap) prow <= ~prow;
      if (prow_wrap) quad <= quad + 2'd1;   // 2-bit natural wrap 3 -> 0
    end
  end

endmodule

// File: rtl/patch_sequencer.sv
// ---------------------------------------------------------------------------
// patch_sequencer
// Walks a 12x12 image as four 6x6 quadrants, each split into four 3x3
// patches, emitting one pixel position per RUN cycle together with the
// strobes that drive column_index_counter and a flat image-buffer address.
// Ports:
//   clock, clear   : clock, synchronous active-high reset
//   start          : begin a full-image pass; sampled only in IDLE
//   busy           : high in LOAD and RUN
//   done           : one-cycle pulse in DONE
//   counter_clear  : holds downstream column counter at its base (not RUN)
//   pixel_valid    : high on every RUN cycle
//   new_row        : last pixel of a kernel row
//   new_vector     : last pixel of a patch
//   quadrant_lsb   : lsb of the NEXT pixel's quadrant (lookahead)
//   quadrant       : quadrant of the current pixel
//   row_index      : image row of the current pixel, 0..11
//   pixel_addr     : row_index*12 + column
//   state          : current FSM state (observability)
// Handshake: start is a level; it is acted on at any edge where the FSM is
// in IDLE and ignored everywhere else, so a start held high re-launches a
// pass straight after the IDLE cycle that follows DONE.
// ---------------------------------------------------------------------------
module patch_sequencer
  import nn_stage1_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              counter_clear,
  output logic              pixel_valid,
  output logic              new_row,
  output logic              new_vector,
  output logic              quadrant_lsb,
  output logic [1:0]        quadrant,
  output logic [3:0]        row_index,
  output logic [ADDR_W-1:0] pixel_addr,
  output state_t            state
);

  logic [1:0]        kcol;
  logic [1:0]        krow;
  logic              pcol;
  logic              prow;
  logic [1:0]        quad;
  logic              kcol_wrap;
  logic              krow_wrap;
  logic              prow_wrap;
  logic              quad_wrap;
  logic              last_sent;   // the pixel on the outputs is pixel 144
  logic              emit;
  logic [3:0]        cur_row;
  logic [3:0]        cur_col;
  logic [ADDR_W-1:0] cur_addr;
  logic              next_quad_lsb;

  // The position counter always holds the next pixel to put on the outputs.
  // Pixel 1 is emitted on the LOAD -> RUN edge.
  assign emit = (state == LOAD) || ((state == RUN) && !last_sent);

  patch_position_counter u_pos (
    .clock     (clock),
    .clear     (clear),
    .advance   (emit),
    .kcol      (kcol),
    .krow      (krow),
    .pcol      (pcol),
    .prow      (prow),
    .quad      (quad),
    .kcol_wrap (kcol_wrap),
    .krow_wrap (krow_wrap),
    .prow_wrap (prow_wrap),
    .quad_wrap (quad_wrap)
  );

  assign cur_row  = (quad[1] ? 4'(QUAD_W) : 4'd0) + (prow ? 4'(KERNEL) : 4'd0) + {2'b00, krow};
  assign cur_col  = (quad[0] ? 4'(QUAD_W) : 4'd0) + (pcol ? 4'(KERNEL) : 4'd0) + {2'b00, kcol};
  assign cur_addr = ADDR_W'(cur_row) * ADDR_W'(IMG_W) + ADDR_W'(cur_col);

  // The quadrant increments exactly when the pixel being emitted closes a
  // quadrant, so the next pixel's quadrant lsb is the current lsb toggled.
  // On pixel 144 this yields 0 because 3 wraps to 0.
  assign next_quad_lsb = quad[0] ^ prow_wrap;

  always_ff @(posedge clock) begin
    if (clear) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      counter_clear <= 1'b1;
      pixel_valid   <= 1'b0;
      new_row       <= 1'b0;
      new_vector    <= 1'b0;
      quadrant_lsb  <= 1'b0;
      quadrant      <= 2'd0;
      row_index     <= 4'd0;
      pixel_addr    <= '0;
      last_sent     <= 1'b0;
    end else begin
      // Non-RUN output values; the emit branch below overrides them.
      busy          <= 1'b0;
      done          <= 1'b0;
      counter_clear <= 1'b1;
      pixel_valid   <= 1'b0;
      new_row       <= 1'b0;
      new_vector    <= 1'b0;
      quadrant_lsb  <= 1'b0;
      quadrant      <= 2'd0;
      row_index     <= 4'd0;
      pixel_addr    <= '0;
      last_sent     <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          state <= RUN;
        end
        RUN: begin
          if (last_sent) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (emit) begin
        busy          <= 1'b1;
        counter_clear <= 1'b0;
        pixel_valid   <= 1'b1;
        new_row       <= kcol_wrap;
        new_vector    <= krow_wrap;
        quadrant_lsb  <= next_quad_lsb;
        quadrant      <= quad;
        row_index     <= cur_row;
        pixel_addr    <= cur_addr;
        last_sent     <= quad_wrap;
      end
    end
  end

endmodule

// File: tb/tb_patch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_patch_sequencer
// Self-checking bench for patch_sequencer. The reference model derives each
// pixel's position from its ordinal number with division/modulo, and an
// expected-address queue is filled per pass and drained pixel by pixel.
// ---------------------------------------------------------------------------
module tb_patch_sequencer;
  import nn_stage1_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       clear;
  logic       start;
  logic       busy;
  logic       done;
  logic       counter_clear;
  logic       pixel_valid;
  logic       new_row;
  logic       new_vector;
  logic       quadrant_lsb;
  logic [1:0] quadrant;
  logic [3:0] row_index;
  logic [7:0] pixel_addr;
  state_t     state;

  always #5 clock = ~clock;

  patch_sequencer #(.ADDR_W(8)) dut (
    .clock         (clock),
    .clear         (clear),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .counter_clear (counter_clear),
    .pixel_valid   (pixel_valid),
    .new_row       (new_row),
    .new_vector    (new_vector),
    .quadrant_lsb  (quadrant_lsb),
    .quadrant      (quadrant),
    .row_index     (row_index),
    .pixel_addr    (pixel_addr),
    .state         (state)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int addr;
    int row;
    int nr;
    int nv;
    int ql;
    int q;
  } pix_t;

  // n is the 1-based pixel number within a pass.
  function automatic pix_t model(input int n);
    pix_t r;
    int i, quad, w, patch, prow, pcol, k, krow, kcol, col;
    i     = n - 1;
    quad  = i / 36;
    w     = i % 36;
    patch = w / 9;
    prow  = patch / 2;
    pcol  = patch % 2;
    k     = w % 9;
    krow  = k / 3;
    kcol  = k % 3;
    r.row  = (quad / 2) * 6 + prow * 3 + krow;
    col    = (quad % 2) * 6 + pcol * 3 + kcol;
    r.addr = r.row * 12 + col;
    r.nr   = (kcol == 2) ? 1 : 0;
    r.nv   = (k == 8) ? 1 : 0;
    r.ql   = ((n % 144) / 36) % 2;   // quadrant of the following pixel
    r.q    = quad;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cap_addr[1:144];
  int cap_nr[1:144];
  int cap_nv[1:144];
  int cap_ql[1:144];
  int cap_q[1:144];

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " state"}, int'(state), int'(IDLE));
    check({tag, " counter_clear"}, int'(counter_clear), 1);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " done"}, int'(done), 0);
    check({tag, " pixel_valid"}, int'(pixel_valid), 0);
    check({tag, " new_row"}, int'(new_row), 0);
    check({tag, " new_vector"}, int'(new_vector), 0);
    check({tag, " quadrant_lsb"}, int'(quadrant_lsb), 0);
    check({tag, " quadrant"}, int'(quadrant), 0);
    check({tag, " row_index"}, int'(row_index), 0);
    check({tag, " pixel_addr"}, int'(pixel_addr), 0);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT in IDLE. poke_at>0 pulses start during
  // that pixel; abort_at>0 asserts clear during that pixel and stops there.
  task automatic run_pass(input bit keep_start, input int poke_at, input int abort_at);
    pix_t m;
    logic [7:0] exp_a;
    for (int n = 1; n <= 144; n++) begin
      m = model(n);
      exp_q.push_back(m.addr[7:0]);
    end
    start = 1'b1;
    @(negedge clock);                       // cycle S+1: LOAD
    if (!keep_start) start = 1'b0;
    check("load state", int'(state), int'(LOAD));
    check("load busy", int'(busy), 1);
    check("load counter_clear", int'(counter_clear), 1);
    check("load pixel_valid", int'(pixel_valid), 0);
    check("load quadrant_lsb", int'(quadrant_lsb), 0);
    for (int p = 1; p <= 144; p++) begin
      @(negedge clock);                     // cycle S+1+p: pixel p
      m = model(p);
      if (exp_q.size() == 0) begin
        exp_a = 8'hxx;
      end else begin
        exp_a = exp_q.pop_front();
      end
      check("pixel_addr", int'(pixel_addr), int'(exp_a));
      check("row_index", int'(row_index), m.row);
      check("new_row", int'(new_row), m.nr);
      check("new_vector", int'(new_vector), m.nv);
      check("quadrant_lsb", int'(quadrant_lsb), m.ql);
      check("quadrant", int'(quadrant), m.q);
      check("run pixel_valid", int'(pixel_valid), 1);
      check("run counter_clear", int'(counter_clear), 0);
      check("run busy", int'(busy), 1);
      check("run done", int'(done), 0);
      cap_addr[p] = int'(pixel_addr);
      cap_nr[p]   = int'(new_row);
      cap_nv[p]   = int'(new_vector);
      cap_ql[p]   = int'(quadrant_lsb);
      cap_q[p]    = int'(quadrant);
      if (poke_at > 0 && p == poke_at) start = 1'b1;
      if (poke_at > 0 && p == poke_at + 1) start = keep_start;
      if (p == abort_at) begin
        clear = 1'b1;
        start = 1'b0;
        @(negedge clock);
        clear = 1'b0;
        check_reset_outs("abort");
        exp_q.delete();
        return;
      end
    end
    @(negedge clock);                       // cycle S+146: DONE
    check("done pulse", int'(done), 1);
    check("done busy", int'(busy), 0);
    check("done state", int'(state), int'(DONE));
    check("done counter_clear", int'(counter_clear), 1);
    check("done pixel_valid", int'(pixel_valid), 0);
    @(negedge clock);                       // cycle S+147: IDLE
    check("post done", int'(done), 0);
    check("post busy", int'(busy), 0);
    check("post state", int'(state), int'(IDLE));
    check("post counter_clear", int'(counter_clear), 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int pix;
    int addr;
    int nr;
    int nv;
    int ql;
    int q;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{pix:1,   addr:0,   nr:0, nv:0, ql:0, q:0};
    vecs[1]  = '{pix:2,   addr:1,   nr:0, nv:0, ql:0, q:0};
    vecs[2]  = '{pix:3,   addr:2,   nr:1, nv:0, ql:0, q:0};
    vecs[3]  = '{pix:4,   addr:12,  nr:0, nv:0, ql:0, q:0};
    vecs[4]  = '{pix:6,   addr:14,  nr:1, nv:0, ql:0, q:0};
    vecs[5]  = '{pix:7,   addr:24,  nr:0, nv:0, ql:0, q:0};
    vecs[6]  = '{pix:9,   addr:26,  nr:1, nv:1, ql:0, q:0};
    vecs[7]  = '{pix:10,  addr:3,   nr:0, nv:0, ql:0, q:0};
    vecs[8]  = '{pix:19,  addr:36,  nr:0, nv:0, ql:0, q:0};
    vecs[9]  = '{pix:36,  addr:65,  nr:1, nv:1, ql:1, q:0};
    vecs[10] = '{pix:37,  addr:6,   nr:0, nv:0, ql:1, q:1};
    vecs[11] = '{pix:72,  addr:71,  nr:1, nv:1, ql:0, q:1};
    vecs[12] = '{pix:73,  addr:72,  nr:0, nv:0, ql:0, q:2};
    vecs[13] = '{pix:144, addr:143, nr:1, nv:1, ql:0, q:3};

    clear = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outs("reset");
    start = 1'b1;                           // clear overrides start
    @(negedge clock);
    check_reset_outs("reset with start");
    start = 1'b0;
    clear = 1'b0;
    @(negedge clock);
    check_reset_outs("idle");

    // First full pass, then the directed table against captured outputs.
    run_pass(1'b0, 0, 0);
    for (int v = 0; v < 14; v++) begin
      check($sformatf("vec%0d addr", vecs[v].pix), cap_addr[vecs[v].pix], vecs[v].addr);
      check($sformatf("vec%0d new_row", vecs[v].pix), cap_nr[vecs[v].pix], vecs[v].nr);
      check($sformatf("vec%0d new_vector", vecs[v].pix), cap_nv[vecs[v].pix], vecs[v].nv);
      check($sformatf("vec%0d quadrant_lsb", vecs[v].pix), cap_ql[vecs[v].pix], vecs[v].ql);
      check($sformatf("vec%0d quadrant", vecs[v].pix), cap_q[vecs[v].pix], vecs[v].q);
    end

    // start pulsed mid-RUN is ignored.
    run_pass(1'b0, 20, 0);

    // Abort at pixel 50, then a fresh pass starts from pixel 1.
    run_pass(1'b0, 0, 50);
    run_pass(1'b0, 0, 0);

    // Back-to-back passes with start held high.
    run_pass(1'b1, 0, 0);
    run_pass(1'b1, 0, 0);
    start = 1'b0;
    @(negedge clock);
    check("idle after b2b", int'(state), int'(IDLE));

    // Randomized idle gaps, mid-run pokes and abort points.
    for (int r = 0; r < 6; r++) begin
      int gap, poke, abort_pt;
      gap      = $urandom_range(0, 5);
      poke     = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 140) : 0;
      abort_pt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 144) : 0;
      repeat (gap) begin
        @(negedge clock);
        check("gap state", int'(state), int'(IDLE));
      end
      run_pass(1'b0, poke, abort_pt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/patch_sequencer.md
Name: patch_sequencer

Overview:
- Upstream control stage for the first-stage 3x3 patch extraction over a 12x12 input image.
- Walks the image as four 6x6 quadrants (00,01,10,11 in raster order), each split into four non-overlapping 3x3 patches (stride 3).
- Emits one pixel position per cycle with the new_row / new_vector / quadrant_lsb strobes that drive column_index_counter.
- Also produces the row index and a flat pixel address for the image buffer read port.

Parameters:
- IMG_W, 12, image width and height in pixels. Fixed: the downstream column counter hardcodes 12.
- QUAD_W, 6, quadrant width and height. Fixed.
- KERNEL, 3, patch edge length and stride. Fixed.
- ADDR_W, 8, pixel_addr width. Must satisfy 2^ADDR_W >= IMG_W*IMG_W.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  synchronous active-high reset.
- start  in  1  begin a full-image pass. Sampled only in IDLE.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse at the end of the pass.
- counter_clear  out  1  drives the downstream column counter's clear input.
- pixel_valid  out  1  high on every RUN cycle.
- new_row  out  1  last pixel of a kernel row (kcol==2).
- new_vector  out  1  last pixel of a patch (kcol==2 and krow==2).
- quadrant_lsb  out  1  lookahead quadrant lsb for the downstream column base.
- quadrant  out  2  quadrant of the current pixel.
- row_index  out  4  image row, 0..11.
- pixel_addr  out  ADDR_W  row_index*IMG_W + column.

Behaviour:
- All outputs are registered.
- Reset: synchronous. clear=1 at an edge forces state IDLE and zeroes all counters. Outputs after that edge:
  - counter_clear=1
  - busy, done, pixel_valid, new_row, new_vector, quadrant_lsb = 0
  - quadrant=0, row_index=0, pixel_addr=0
- clear overrides start and aborts a pass in progress. No done is issued for an aborted pass.
- FSM states and transitions:
  - IDLE -> LOAD when start=1.
  - LOAD -> RUN unconditionally.
  - RUN -> DONE after the 144th pixel.
  - DONE -> IDLE unconditionally.
- counter_clear=1 in IDLE, LOAD and DONE; 0 in RUN. The downstream counter therefore holds its base value, and the first RUN cycle sees column 0.
- Timing:
  - start sampled at edge S.
  - Cycle S+1: LOAD.
  - Cycles S+2..S+145: RUN, 144 pixels.
  - Cycle S+146: DONE, done=1.
  - Cycle S+147: IDLE.
- start is ignored outside IDLE. A start held high in IDLE after DONE launches the next pass immediately.
- Counter nesting, innermost first:
  - kcol 0..2
  - krow 0..2
  - pcol 0..1
  - prow 0..1
  - quad 0..3
- Each counter wraps to 0 when it saturates and carries into the next one.
- row_index = quad[1]*6 + prow*3 + krow.
- Internal column shadow = quad[0]*6 + pcol*3 + kcol. It must equal the downstream column_index on every RUN cycle.
- pixel_addr = row_index*12 + column, computed in ADDR_W bits. No overflow is possible at the defaults.
- new_row is asserted on every kcol==2, including the cycle where new_vector=1. The downstream counter ignores the restart when new_vector is set.
- quadrant_lsb is a lookahead: it equals the lsb of the quadrant of the *next* pixel.
  - It therefore changes on the last pixel of a quadrant (pixels 36, 72, 108), in the same cycle the downstream counter reloads its base.
  - On pixel 144 it shows 0, because the quadrant wraps.
  - In LOAD it shows 0.
- quadrant (2 bits) shows the current pixel's quadrant, with no lookahead.

Decomposition:
- Shared package (nn_stage1_pkg): IMG_W, QUAD_W, KERNEL, PIXELS_PER_PASS=144, and the state encoding IDLE/LOAD/RUN/DONE.
- column_index_counter should import the same constants.
- One natural sub-module: patch_position_counter, holding the nested kcol/krow/pcol/prow/quad counters with a single advance input and wrap outputs.
- The FSM, lookahead logic and address arithmetic stay in the top module.

Test Plan:
- Reset then start:
  - counter_clear high through LOAD.
  - Pixels 1..9 give pixel_addr 0,1,2,12,13,14,24,25,26.
  - new_row on pixels 3, 6, 9.
  - new_vector only on pixel 9.
  - Pixel 10 addr=3.
- Quadrant boundaries:
  - Pixel 19 addr=36 (prow=1).
  - quadrant_lsb rises on pixel 36.
  - Pixel 37 addr=6, quadrant=1.
  - Pixel 72 drops quadrant_lsb to 0.
  - Pixel 73 addr=72, quadrant=2.
  - Pixel 144 addr=143.
- Completion: done high exactly at S+146 for one cycle, busy low at S+146, IDLE at S+147. A start pulsed mid-RUN has no effect.
- Co-simulation with column_index_counter: downstream column_index equals the internal column shadow on all 144 RUN cycles.
- Abort: clear asserted at pixel 50 -> next cycle is IDLE with all outputs at reset values. A fresh start then yields pixel 1 addr=0.
- Back-to-back passes: start held high continuously -> DONE, IDLE, LOAD, then a second pass with identical address sequence.
